// File: rtl/shift_unit_p.sv
// -----------------------------------------------------------------------------
// shift_unit_p
//
// Purpose
//   WIDTH-bit shift register. It can hold, shift left, shift right, rotate and
//   load in parallel. An internal counter tracks accepted shifts, and a
//   registered pulse on 'frame' marks each completed group of WIDTH shifts.
//
// Configuration
//   SHIFT_MATCH_EN  When defined, adds the PATTERN parameter, the 'match'
//                   output and an equality comparator on 'out'. When
//                   undefined, all of these are absent and the rest of the
//                   behaviour is identical.
//
// Parameters
//   WIDTH    register width in bits, 2..32 (default 4)
//   PATTERN  match value, WIDTH bits (default 4'b1011), SHIFT_MATCH_EN only
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-low reset
//   en     in   operation enable; 0 holds all state
//   mode   in   [1:0] 00 hold, 01 shift left, 10 shift right, 11 load
//   rot    in   1 = rotate; the shifted-out bit is used as the fill bit
//   x      in   serial fill bit when rot = 0
//   din    in   [WIDTH-1:0] parallel load data
//   out    out  [WIDTH-1:0] register contents (registered)
//   so     out  bit most recently shifted out (registered)
//   frame  out  one-cycle pulse after every WIDTH-th shift (registered)
//   match  out  out == PATTERN, combinational (SHIFT_MATCH_EN only)
// -----------------------------------------------------------------------------
module shift_unit_p #(
    parameter int unsigned WIDTH = 4
`ifdef SHIFT_MATCH_EN
    ,
    parameter logic [WIDTH-1:0] PATTERN = WIDTH'(4'b1011)
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             rot,
    input  logic             x,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] out,
    output logic             so,
    output logic             frame
`ifdef SHIFT_MATCH_EN
    ,
    output logic             match
`endif
);

    // -------------------------------------------------------------------------
    // Local types and constants
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        OP_HOLD  = 2'b00,
        OP_SHL   = 2'b01,
        OP_SHR   = 2'b10,
        OP_LOAD  = 2'b11
    } op_e;

    // The counter only needs to reach WIDTH-1. For WIDTH=2 this is one bit.
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] out_q,   out_d;
    logic             so_q,    so_d;
    logic             frame_q, frame_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    op_e              op;
    logic             shift_fire;   // a left or right shift is accepted this cycle
    logic             fill_left;    // bit entering at bit 0 on a left shift
    logic             fill_right;   // bit entering at the MSB on a right shift

    assign op = op_e'(mode);

    // When rotating, the fill bit is the bit leaving the other end. Otherwise
    // it is the serial input x.
    assign fill_left  = rot ? out_q[WIDTH-1] : x;
    assign fill_right = rot ? out_q[0]       : x;

    assign shift_fire = en && ((op == OP_SHL) || (op == OP_SHR));

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal gets a default at the top of the block. Any path that
    // does not assign a signal then keeps that default, so no latch is
    // inferred.
    always_comb begin
        out_d   = out_q;
        so_d    = so_q;
        cnt_d   = cnt_q;
        frame_d = 1'b0;

        if (en) begin
            unique case (op)
                OP_HOLD: begin
                    // Keep every register; frame stays low.
                end
                OP_SHL: begin
                    out_d = {out_q[WIDTH-2:0], fill_left};
                    so_d  = out_q[WIDTH-1];
                end
                OP_SHR: begin
                    out_d = {fill_right, out_q[WIDTH-1:1]};
                    so_d  = out_q[0];
                end
                OP_LOAD: begin
                    // A load starts a new frame. so keeps its last shifted-out bit.
                    out_d = din;
                    cnt_d = '0;
                end
                default: begin
                end
            endcase
        end

        // The counter ignores direction, so switching left/right mid-frame
        // keeps the partial count. The wrap from WIDTH-1 raises frame for the
        // following cycle. The next shift counts from zero, so back-to-back
        // frames have no gap between them.
        if (shift_fire) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                frame_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments (<=). All registers
    // then update together from values sampled before the edge, which avoids
    // ordering races between always blocks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: all of this state is control-visible, so every register is
            // cleared on reset. Reset works without a clock, so a partial
            // shift count is discarded at once.
            out_q   <= '0;
            so_q    <= 1'b0;
            frame_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            out_q   <= out_d;
            so_q    <= so_d;
            frame_q <= frame_d;
            cnt_q   <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign out   = out_q;
    assign so    = so_q;
    assign frame = frame_q;

`ifdef SHIFT_MATCH_EN
    // Decoded from the register output, so a load or a shift shows on match
    // in the same cycle it shows on out.
    assign match = (out_q == PATTERN);
`endif

endmodule

// File: tb/tb_shift_unit_p.sv
// -----------------------------------------------------------------------------
// tb_shift_unit_p
//
// Self-checking bench for shift_unit_p with WIDTH = 4. The reference model
// holds the register value as a plain integer and counts shifts since the
// last frame boundary. A frame is complete when that count reaches WIDTH.
// Directed scenarios cover reset, frame timing, rotate, hold/load and reset
// mid-frame. A randomized run then compares every cycle against the model.
// Build with +define+SHIFT_MATCH_EN to add the match checks.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_shift_unit_p;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         en;
    logic [1:0]   mode;
    logic         rot;
    logic         x;
    logic [W-1:0] din;
    logic [W-1:0] out;
    logic         so;
    logic         frame;
`ifdef SHIFT_MATCH_EN
    logic         match;
`endif

    shift_unit_p #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .mode  (mode),
        .rot   (rot),
        .x     (x),
        .din   (din),
        .out   (out),
        .so    (so),
        .frame (frame)
`ifdef SHIFT_MATCH_EN
        ,
        .match (match)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    int unsigned m_val;      // register value, 0 .. 2**W-1
    int unsigned m_so;
    int unsigned m_frame;
    int          m_shifts;   // shifts since last frame boundary

    task automatic model_reset();
        m_val = 0; m_so = 0; m_frame = 0; m_shifts = 0;
    endtask

    task automatic model_step(input logic e, input logic [1:0] md, input logic r,
                              input logic xi, input logic [W-1:0] d);
        int unsigned top, bot, fill;
        m_frame = 0;
        if (!e || md == 2'd0) return;
        if (md == 2'd3) begin
            m_val = d; m_shifts = 0;
            return;
        end
        top = (m_val / (1 << (W-1))) % 2;
        bot = m_val % 2;
        if (md == 2'd1) begin
            fill  = r ? top : xi;
            m_val = (m_val * 2 + fill) % (1 << W);
            m_so  = top;
        end else begin
            fill  = r ? bot : xi;
            m_val = m_val / 2 + fill * (1 << (W-1));
            m_so  = bot;
        end
        m_shifts++;
        if (m_shifts == W) begin
            m_frame  = 1;
            m_shifts = 0;
        end
    endtask

    // Drive one operation, clock it, update the model and compare after the edge.
    task automatic apply(input logic e, input logic [1:0] md, input logic r,
                         input logic xi, input logic [W-1:0] d, input string tag);
        en = e; mode = md; rot = r; x = xi; din = d;
        @(posedge clk);
        model_step(e, md, r, xi, d);
        #1;
        check({tag, ".out"},   32'(out),   32'(m_val));
        check({tag, ".so"},    32'(so),    32'(m_so));
        check({tag, ".frame"}, 32'(frame), 32'(m_frame));
`ifdef SHIFT_MATCH_EN
        check({tag, ".match"}, 32'(match), 32'(m_val == 4'b1011));
`endif
    endtask

    // Assert reset between clock edges and check that it acts at once.
    task automatic async_reset(input string tag);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check({tag, ".out"},   32'(out),   32'd0);
        check({tag, ".so"},    32'(so),    32'd0);
        check({tag, ".frame"}, 32'(frame), 32'd0);
        #2 reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; mode = 2'b00; rot = 1'b0; x = 1'b0; din = '0;
        model_reset();

        // Reset state, before and across a clock edge.
        #3;
        check("rst0.out",   32'(out),   32'd0);
        check("rst0.so",    32'(so),    32'd0);
        check("rst0.frame", 32'(frame), 32'd0);
        @(posedge clk); #3;
        check("rst1.out", 32'(out), 32'd0);
        reset = 1'b1;

        // Frame: shift in ones from 0000.
        apply(1, 2'b01, 0, 1, 4'h0, "frm1"); check("frm1.exp", 32'(out), 32'h1);
        check("frm1.nofr", 32'(frame), 32'd0);
        apply(1, 2'b01, 0, 1, 4'h0, "frm2"); check("frm2.exp", 32'(out), 32'h3);
        apply(1, 2'b01, 0, 1, 4'h0, "frm3"); check("frm3.exp", 32'(out), 32'h7);
        check("frm3.nofr", 32'(frame), 32'd0);
        apply(1, 2'b01, 0, 1, 4'h0, "frm4"); check("frm4.exp", 32'(out), 32'hF);
        check("frm4.frame", 32'(frame), 32'd1);
        apply(1, 2'b00, 0, 1, 4'h0, "frm5"); check("frm5.frame", 32'(frame), 32'd0);

        // Rotate right after a load.
        apply(1, 2'b11, 0, 0, 4'hA, "rot0");
        apply(1, 2'b10, 1, 1, 4'h0, "rot1");
        check("rot1.exp", 32'(out), 32'h5); check("rot1.so", 32'(so), 32'd0);
        apply(1, 2'b10, 1, 1, 4'h0, "rot2");
        check("rot2.exp", 32'(out), 32'hA); check("rot2.so", 32'(so), 32'd1);

        // Hold with en=0, then a load in mid-frame clears the count.
        apply(0, 2'b01, 0, 1, 4'h0, "hold");
        check("hold.exp", 32'(out), 32'hA); check("hold.frame", 32'(frame), 32'd0);
        apply(1, 2'b01, 0, 0, 4'h0, "ld_s1");
        apply(1, 2'b01, 0, 0, 4'h0, "ld_s2");
        apply(1, 2'b11, 0, 0, 4'hC, "ld");
        check("ld.exp", 32'(out), 32'hC);
        for (int i = 0; i < 3; i++) begin
            apply(1, 2'b10, 0, 0, 4'h0, "ld_pre");
            check("ld_pre.nofr", 32'(frame), 32'd0);
        end
        apply(1, 2'b01, 0, 0, 4'h0, "ld_4th");
        check("ld_4th.frame", 32'(frame), 32'd1);

        // Reset mid-frame discards the partial count.
        apply(1, 2'b01, 0, 1, 4'h0, "rmf_a");
        apply(1, 2'b01, 0, 1, 4'h0, "rmf_b");
        async_reset("rmf_rst");
        for (int i = 0; i < 3; i++) begin
            apply(1, 2'b01, 0, 1, 4'h0, "rmf_pre");
            check("rmf_pre.nofr", 32'(frame), 32'd0);
        end
        apply(1, 2'b01, 0, 1, 4'h0, "rmf_4th");
        check("rmf_4th.frame", 32'(frame), 32'd1);

        // Back-to-back frames: a pulse on every fourth shift, no dead cycle.
        for (int i = 1; i <= 8; i++) begin
            apply(1, (i % 3 == 0) ? 2'b10 : 2'b01, 1'(i % 2), 1'(i / 2), 4'h0, "b2b");
            check("b2b.frame", 32'(frame), 32'(i % 4 == 0));
        end

`ifdef SHIFT_MATCH_EN
        // Match while out equals 1011.
        async_reset("m_rst");
        apply(1, 2'b01, 0, 1, 4'h0, "m1");
        apply(1, 2'b01, 0, 0, 4'h0, "m2");
        apply(1, 2'b01, 0, 1, 4'h0, "m3");
        apply(1, 2'b01, 0, 1, 4'h0, "m4");
        check("m4.match", 32'(match), 32'd1);
        apply(1, 2'b01, 0, 0, 4'h0, "m5");
        check("m5.match", 32'(match), 32'd0);
        apply(1, 2'b11, 0, 0, 4'hB, "mld");
        check("mld.match", 32'(match), 32'd1);
`endif

        // Randomized run with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) async_reset("rnd_rst");
            apply(($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom),
                  1'($urandom), 4'($urandom), "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_unit_p.md
SHIFT_UNIT_P -- requirements
Module: shift_unit_p

Interface
REQ-001 Parameter WIDTH, default 4: register width in bits; legal range 2..32.
REQ-002 Parameter PATTERN, default 4'b1011, WIDTH bits: match value, used only when SHIFT_MATCH_EN is defined.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1: asynchronous, active-low reset.
REQ-005 Port en  input  1: operation enable; 0 holds all state regardless of other inputs.
REQ-006 Port mode  input  2: operation select; 00 hold, 01 shift left, 10 shift right, 11 parallel load.
REQ-007 Port rot  input  1: 1 selects rotate; the shifted-out bit replaces x as the fill bit.
REQ-008 Port x  input  1: serial fill bit for shifts when rot=0.
REQ-009 Port din  input  WIDTH: parallel load data.
REQ-010 Port out  output  WIDTH: register contents, registered.
REQ-011 Port so  output  1: registered; the bit most recently shifted out.
REQ-012 Port frame  output  1: registered one-cycle pulse marking completion of WIDTH shifts.
REQ-013 Port match  output  1: present only with SHIFT_MATCH_EN; high when out == PATTERN.

Function
REQ-014 en=0 or mode=00 shall hold out, so and the shift counter; frame shall be 0 in that cycle.
REQ-015 Shift left shall load out <= {out[WIDTH-2:0], fill} and so <= out[WIDTH-1].
REQ-016 Shift right shall load out <= {fill, out[WIDTH-1:1]} and so <= out[0].
REQ-017 fill shall be x when rot=0; otherwise the bit being shifted out, so the register rotates.
REQ-018 Parallel load shall load out <= din, leave so unchanged, clear the shift counter and drive frame to 0.
REQ-019 Shift counter: internal, counts accepted shifts (left or right) 0..WIDTH-1; direction changes mid-frame do not reset it.
REQ-020 On the shift that takes the counter from WIDTH-1, the counter shall wrap to 0 and frame shall be 1 for exactly the following cycle.
REQ-021 Back-to-back frames shall produce one frame pulse every WIDTH shifts with no dead cycle.
REQ-022 Latency: every operation is visible on out/so/frame one clock after the edge at which it is sampled.
REQ-023 match shall be combinational from out, with no added latency.
REQ-024 Inputs x, din and rot shall be ignored when the selected operation does not use them.

Reset
REQ-025 reset=0 shall immediately force out=0, so=0, frame=0 and counter=0, independent of clk.
REQ-026 Reset asserted mid-frame shall discard the partial count; the next frame requires a full WIDTH shifts.
REQ-027 After reset deasserts, the first operation shall be sampled at the first rising clk edge with reset=1.

Configuration
REQ-028 Macro SHIFT_MATCH_EN defined: the match port and comparator shall be present, with match=1 whenever out==PATTERN, including after a load.
REQ-029 Macro SHIFT_MATCH_EN undefined: the match port and all comparator logic shall be absent; all other behaviour shall be identical.

Verification (WIDTH=4)
REQ-030 Reset: drive reset=0 mid-cycle -> out=0000, so=0 and frame=0 immediately, before the next clk edge.
REQ-031 Frame: en=1, mode=01, rot=0, x=1 for 4 cycles from 0000 -> out goes 0001, 0011, 0111, 1111; frame=1 only in the cycle after the 4th shift.
REQ-032 Rotate: load din=1010, then mode=10, rot=1 -> out=0101, so=0; next shift -> out=1010, so=1.
REQ-033 Hold and load: en=0 with mode=01 -> out unchanged and frame=0; load 1100 after 2 shifts -> counter cleared, so the next frame needs 4 shifts.
REQ-034 Reset mid-frame: 2 shifts, pulse reset low, then 3 shifts -> no frame pulse; the 4th shift produces the pulse.
REQ-035 Match (SHIFT_MATCH_EN defined, PATTERN=1011): shift left x=1,0,1,1 from 0000 -> match=1 exactly while out=1011.
